// File: rtl/dcache_d0_skid.sv
// Dcache request stage: address split, lane-aligned byte mask and store data,
// misalignment detect, round-robin fill victim, and a two-entry skid buffer.
`ifndef PCYN_LSU_FUNC_WIDTH
`define PCYN_LSU_FUNC_WIDTH 4
`endif

module dcache_d0_skid #(
    parameter  int unsigned OPTN_DATA_WIDTH    = 32,
    parameter  int unsigned OPTN_ADDR_WIDTH    = 32,
    parameter  int unsigned OPTN_DC_CACHE_SIZE = 1024,
    parameter  int unsigned OPTN_DC_LINE_SIZE  = 32,
    parameter  int unsigned OPTN_DC_WAY_COUNT  = 1,
    localparam int unsigned WORD_SIZE = OPTN_DATA_WIDTH / 8,
    localparam int unsigned BO_W      = $clog2(WORD_SIZE),
    localparam int unsigned OFFSET_W  = $clog2(OPTN_DC_LINE_SIZE),
    localparam int unsigned SET_COUNT = OPTN_DC_CACHE_SIZE / (OPTN_DC_LINE_SIZE * OPTN_DC_WAY_COUNT),
    localparam int unsigned INDEX_W   = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1,
    localparam int unsigned TAG_W     = OPTN_ADDR_WIDTH - INDEX_W - OFFSET_W,
    localparam int unsigned LINE_W    = OPTN_DC_LINE_SIZE * 8,
    localparam int unsigned WAY_W     = (OPTN_DC_WAY_COUNT > 1) ? $clog2(OPTN_DC_WAY_COUNT) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic                            i_wr_en,
    input  logic                            i_fill,
    input  logic                            i_dirty,
    input  logic                            i_line_valid,
    input  logic [OPTN_ADDR_WIDTH-1:0]      i_addr,
    input  logic [`PCYN_LSU_FUNC_WIDTH-1:0] i_lsu_func,
    input  logic [OPTN_DATA_WIDTH-1:0]      i_data,
    input  logic [LINE_W-1:0]               i_fill_data,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic                            o_wr_en,
    output logic                            o_fill,
    output logic                            o_dirty,
    output logic                            o_line_valid,
    output logic [TAG_W-1:0]                o_tag,
    output logic [INDEX_W-1:0]              o_index,
    output logic [OFFSET_W-1:0]             o_offset,
    output logic [WORD_SIZE-1:0]            o_byte_sel,
    output logic [OPTN_DATA_WIDTH-1:0]      o_data,
    output logic                            o_misaligned,
    output logic [WAY_W-1:0]                o_way,
    output logic [LINE_W-1:0]               o_fill_data
);

    localparam logic [`PCYN_LSU_FUNC_WIDTH-1:0] LSU_LB  = 'h0;
    localparam logic [`PCYN_LSU_FUNC_WIDTH-1:0] LSU_LH  = 'h1;
    localparam logic [`PCYN_LSU_FUNC_WIDTH-1:0] LSU_LBU = 'h4;
    localparam logic [`PCYN_LSU_FUNC_WIDTH-1:0] LSU_LHU = 'h5;
    localparam logic [`PCYN_LSU_FUNC_WIDTH-1:0] LSU_SB  = 'h8;
    localparam logic [`PCYN_LSU_FUNC_WIDTH-1:0] LSU_SH  = 'h9;

    typedef struct packed {
        logic                       wr_en;
        logic                       fill;
        logic                       dirty;
        logic                       line_valid;
        logic [TAG_W-1:0]           tag;
        logic [INDEX_W-1:0]         index;
        logic [OFFSET_W-1:0]        offset;
        logic [WORD_SIZE-1:0]       byte_sel;
        logic [OPTN_DATA_WIDTH-1:0] data;
        logic                       misaligned;
        logic [WAY_W-1:0]           way;
        logic [LINE_W-1:0]          fill_data;
    } req_t;

    req_t                 r_main, r_skid, w_req;
    logic                 r_valid, r_skid_valid;
    logic [WAY_W-1:0]     r_rr [1 << INDEX_W];
    logic [BO_W-1:0]      w_bo;
    logic [INDEX_W-1:0]   w_index;
    logic [WORD_SIZE-1:0] w_mask;
    logic                 w_half, w_word, w_mis, w_acc;

    assign o_ready = ~r_skid_valid & ~rst;
    assign w_acc   = i_valid & o_ready;
    assign w_index = i_addr[OFFSET_W +: INDEX_W];

    always_comb begin
        w_bo   = i_addr[BO_W-1:0];
        w_half = 1'b0;
        w_word = 1'b0;
        w_mask = '1;
        case (i_lsu_func)
            LSU_LB, LSU_LBU, LSU_SB: w_mask = WORD_SIZE'(1);
            LSU_LH, LSU_LHU, LSU_SH: begin
                w_mask = WORD_SIZE'(3);
                w_half = 1'b1;
            end
            default: w_word = 1'b1;
        endcase
        // Fills carry whole lines, so the LSU size/alignment rules do not apply.
        w_mis = ~i_fill & ((w_half & w_bo[0]) | (w_word & (w_bo != '0)));

        w_req            = '0;
        w_req.wr_en      = i_wr_en & ~w_mis;
        w_req.fill       = i_fill;
        w_req.dirty      = i_dirty;
        w_req.line_valid = i_line_valid;
        w_req.tag        = i_addr[OFFSET_W + INDEX_W +: TAG_W];
        w_req.index      = w_index;
        w_req.offset     = i_addr[OFFSET_W-1:0];
        w_req.byte_sel   = i_fill ? '1 : (w_mis ? '0 : (w_mask << w_bo));
        w_req.data       = i_data << {w_bo, 3'b000};
        w_req.misaligned = w_mis;
        w_req.way        = i_fill ? r_rr[w_index] : '0;
        w_req.fill_data  = i_fill_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (~r_valid | i_ready) begin
            // Skid can only be full while o_ready is low, so no accept competes here.
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_valid      <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_acc) begin
                r_main  <= w_req;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end else if (w_acc) begin
            r_skid       <= w_req;
            r_skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < (1 << INDEX_W); s++) r_rr[s] <= '0;
        end else if (w_acc & i_fill) begin
            r_rr[w_index] <= (OPTN_DC_WAY_COUNT > 1) ? r_rr[w_index] + WAY_W'(1) : '0;
        end
    end

    assign o_valid      = r_valid;
    assign o_wr_en      = r_main.wr_en;
    assign o_fill       = r_main.fill;
    assign o_dirty      = r_main.dirty;
    assign o_line_valid = r_main.line_valid;
    assign o_tag        = r_main.tag;
    assign o_index      = r_main.index;
    assign o_offset     = r_main.offset;
    assign o_byte_sel   = r_main.byte_sel;
    assign o_data       = r_main.data;
    assign o_misaligned = r_main.misaligned;
    assign o_way        = r_main.way;
    assign o_fill_data  = r_main.fill_data;

endmodule

// File: tb/tb_dcache_d0_skid.sv
// Bench for dcache_d0_skid: directed scenarios plus random flow control against a queue model.
module tb_dcache_d0_skid;

    localparam logic [3:0] LB = 4'h0, LH = 4'h1, LW = 4'h2, LBU = 4'h4, LHU = 4'h5;
    localparam logic [3:0] SB = 4'h8, SH = 4'h9, SW = 4'hA;

    logic         clk = 1'b0;
    logic         rst, i_valid, i_ready, i_wr_en, i_fill, i_dirty, i_line_valid;
    logic [31:0]  i_addr, i_data;
    logic [3:0]   i_lsu_func;
    logic [255:0] i_fill_data;
    logic         o_ready, o_valid, o_wr_en, o_fill, o_dirty, o_line_valid, o_misaligned;
    logic [22:0]  o_tag;
    logic [3:0]   o_index;
    logic [4:0]   o_offset;
    logic [3:0]   o_byte_sel;
    logic [31:0]  o_data;
    logic [0:0]   o_way;
    logic [255:0] o_fill_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         wr_en, fill, dirty, lv, mis;
        bit [22:0]  tag;
        bit [3:0]   index;
        bit [4:0]   offset;
        bit [3:0]   bsel;
        bit [31:0]  data;
        bit         way;
        bit [255:0] fd;
    } exp_t;

    exp_t        q[$];
    int unsigned rr[16];
    bit          rst_edge;

    always #5 clk = ~clk;

    dcache_d0_skid #(
        .OPTN_DATA_WIDTH(32),
        .OPTN_ADDR_WIDTH(32),
        .OPTN_DC_CACHE_SIZE(1024),
        .OPTN_DC_LINE_SIZE(32),
        .OPTN_DC_WAY_COUNT(2)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_wr_en(i_wr_en), .i_fill(i_fill), .i_dirty(i_dirty), .i_line_valid(i_line_valid),
        .i_addr(i_addr), .i_lsu_func(i_lsu_func), .i_data(i_data), .i_fill_data(i_fill_data),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_wr_en(o_wr_en), .o_fill(o_fill), .o_dirty(o_dirty), .o_line_valid(o_line_valid),
        .o_tag(o_tag), .o_index(o_index), .o_offset(o_offset), .o_byte_sel(o_byte_sel),
        .o_data(o_data), .o_misaligned(o_misaligned), .o_way(o_way), .o_fill_data(o_fill_data)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t build();
        exp_t e;
        int unsigned bo, sz;
        bo = i_addr % 4;
        case (i_lsu_func)
            LB, LBU, SB: sz = 1;
            LH, LHU, SH: sz = 2;
            default:     sz = 4;
        endcase
        e.index  = 4'((i_addr / 32) % 16);
        e.tag    = 23'(i_addr / 512);
        e.offset = 5'(i_addr % 32);
        if (i_fill) begin
            e.mis  = 1'b0;
            e.bsel = 4'hF;
        end else begin
            e.mis  = (bo % sz) != 0;
            e.bsel = e.mis ? 4'h0 : 4'(((1 << sz) - 1) << bo);
        end
        e.data  = i_data << (8 * bo);
        e.wr_en = i_wr_en && !e.mis;
        e.fill  = i_fill;
        e.dirty = i_dirty;
        e.lv    = i_line_valid;
        e.way   = i_fill ? rr[e.index][0] : 1'b0;
        e.fd    = i_fill_data;
        return e;
    endfunction

    task automatic check_model();
        chk("o_ready", o_ready, (!rst && q.size() < 2));
        chk("o_valid", o_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("wr_en", o_wr_en, q[0].wr_en);
            chk("fill", o_fill, q[0].fill);
            chk("dirty", o_dirty, q[0].dirty);
            chk("line_valid", o_line_valid, q[0].lv);
            chk("tag", o_tag, q[0].tag);
            chk("index", o_index, q[0].index);
            chk("offset", o_offset, q[0].offset);
            chk("byte_sel", o_byte_sel, q[0].bsel);
            chk("data", o_data, q[0].data);
            chk("misaligned", o_misaligned, q[0].mis);
            chk("way", o_way, q[0].way);
            chk("fill_data", o_fill_data, q[0].fd);
        end else if (rst_edge) begin
            chk("rst_byte_sel", o_byte_sel, 0);
            chk("rst_data", o_data, 0);
            chk("rst_way", o_way, 0);
            chk("rst_fill_data", o_fill_data, 0);
            chk("rst_tag", o_tag, 0);
        end
    endtask

    task automatic step();
        exp_t e;
        bit acc, drn;
        e = build();
        @(posedge clk);
        rst_edge = rst;
        if (rst) begin
            q.delete();
            foreach (rr[s]) rr[s] = 0;
        end else begin
            acc = i_valid && q.size() < 2;
            drn = q.size() > 0 && i_ready;
            if (drn) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                if (i_fill) rr[e.index] = (rr[e.index] + 1) % 2;
            end
        end
        #1;
        check_model();
    endtask

    task automatic drive(input bit v, input bit [3:0] f, input bit [31:0] a,
                         input bit [31:0] d, input bit wr, input bit fl);
        i_valid      = v;
        i_lsu_func   = f;
        i_addr       = a;
        i_data       = d;
        i_wr_en      = wr;
        i_fill       = fl;
        i_dirty      = 1'($urandom);
        i_line_valid = 1'($urandom);
        for (int k = 0; k < 8; k++) i_fill_data[k*32 +: 32] = $urandom;
    endtask

    initial begin
        bit [3:0] funcs[8];
        funcs = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
        rst = 1'b1;
        i_ready = 1'b1;
        drive(1, LW, 32'h40, 32'h1234, 1, 0);
        step();
        step();
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_ready_held", o_ready, 0);
        rst = 1'b0;
        drive(0, LW, 0, 0, 0, 0);
        step();
        chk("post_rst_o_ready", o_ready, 1);

        // back-to-back loads, one per cycle
        drive(1, LB, 32'h103, 32'h0, 0, 0); step();
        chk("lb_bsel", o_byte_sel, 4'b1000);
        chk("lb_index", o_index, 8);
        chk("lb_offset", o_offset, 3);
        drive(1, LH, 32'h102, 32'h0, 0, 0); step();
        chk("lh_bsel", o_byte_sel, 4'b1100);
        chk("lh_offset", o_offset, 2);
        drive(1, LW, 32'h100, 32'h0, 0, 0); step();
        chk("lw_bsel", o_byte_sel, 4'b1111);
        chk("lw_offset", o_offset, 0);

        drive(1, SB, 32'h001, 32'hAB, 1, 0); step();
        chk("sb_data", o_data, 32'h0000AB00);
        chk("sb_bsel", o_byte_sel, 4'b0010);
        chk("sb_wr_en", o_wr_en, 1);
        drive(1, SH, 32'h003, 32'hBEEF, 1, 0); step();
        chk("sh_mis", o_misaligned, 1);
        chk("sh_bsel", o_byte_sel, 0);
        chk("sh_wr_en", o_wr_en, 0);
        drive(0, LW, 0, 0, 0, 0); step();

        // stall: A into main, B into skid, C refused until re-sent
        drive(1, LW, 32'h200, 32'hAAAA0001, 0, 0); step();
        i_ready = 1'b0;
        drive(1, LW, 32'h204, 32'hBBBB0002, 0, 0); step();
        drive(1, LW, 32'h208, 32'hCCCC0003, 0, 0); step();
        chk("stall_ready", o_ready, 0);
        chk("stall_hold_a", o_data, 32'hAAAA0001);
        step();
        chk("stall_hold_a2", o_data, 32'hAAAA0001);
        i_ready = 1'b1;
        step();
        chk("drain_b", o_data, 32'hBBBB0002);
        step();
        chk("drain_c", o_data, 32'hCCCC0003);
        drive(0, LW, 0, 0, 0, 0); step();
        chk("drain_empty", o_valid, 0);

        // round-robin fill victims
        drive(1, LW, 32'hA0, 0, 0, 1); step();
        chk("fill5_a", o_way, 0);
        drive(1, LW, 32'hA4, 0, 0, 1); step();
        chk("fill5_b", o_way, 1);
        drive(1, LW, 32'hC0, 0, 0, 1); step();
        chk("fill6", o_way, 0);
        drive(1, LB, 32'hA1, 0, 0, 1); step();
        chk("fill5_c", o_way, 0);
        chk("fill_bsel", o_byte_sel, 4'hF);
        chk("fill_mis", o_misaligned, 0);

        // reset with skid full
        drive(1, LW, 32'hA0, 0, 0, 1); step();
        i_ready = 1'b0;
        drive(1, LW, 32'h300, 32'h55, 0, 0); step();
        drive(0, LW, 0, 0, 0, 0); step();
        chk("skid_full_ready", o_ready, 0);
        rst = 1'b1;
        drive(1, LW, 32'h44, 32'h77, 1, 0);
        step();
        chk("rst_skid_valid", o_valid, 0);
        rst = 1'b0;
        i_ready = 1'b1;
        drive(0, LW, 0, 0, 0, 0);
        #1;
        chk("rst_skid_ready", o_ready, 1);
        drive(1, LW, 32'hA0, 0, 0, 1); step();
        chk("fill5_after_rst", o_way, 0);

        // random flow control
        for (int n = 0; n < 10000; n++) begin
            drive(1'($urandom), funcs[$urandom_range(0, 7)], $urandom, $urandom,
                  1'($urandom), ($urandom_range(0, 3) == 0));
            i_ready = 1'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
